// File: rtl/glip_jtag_pkg.sv
// Shared helpers for the GLIP JTAG blocks: ceil-log2 and the fill-counter width rule.
package glip_jtag_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // A counter that must represent 0..depth inclusive needs one bit more than the address.
  function automatic int count_width(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/glip_jtag_pfifo_ram.sv
// Storage array for glip_jtag_pfifo: one synchronous write port, one asynchronous read port.
module glip_jtag_pfifo_ram
  import glip_jtag_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  // Contents are deliberately not reset; the control logic masks stale entries.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/glip_jtag_pfifo.sv
// First-word fall-through FIFO with fill status and optional packet mode.
// Packet mode (in_last stored, out_valid held until a complete packet) is enabled by GLIP_JTAG_PFIFO_PACKET_EN.
module glip_jtag_pfifo
  import glip_jtag_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 16,
  parameter  int AF_THRESH  = DEPTH - 2,
  parameter  int AE_THRESH  = 2,
  localparam int CW         = count_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CW-1:0]         fill_level,
  output logic [CW-1:0]         free_space,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam int AW = clog2(DEPTH);
`ifdef GLIP_JTAG_PFIFO_PACKET_EN
  localparam int WW = DATA_WIDTH + 1;
`else
  localparam int WW = DATA_WIDTH;
`endif

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [WW-1:0] wr_word, rd_word;
  logic          push, pop;
  logic [CW-1:0] fill_next;

  // Handshake: a word moves only when valid and ready are both high at a rising edge;
  // ready never looks at valid, and valid never looks at ready, on either side.
  assign in_ready = (fill_level != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  always_comb begin
    fill_next = fill_level;
    if (push && !pop)      fill_next = fill_level + CW'(1);
    else if (pop && !push) fill_next = fill_level - CW'(1);
  end

  // Status flags are registered from the next fill value so they line up with fill_level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill_level   <= '0;
      free_space   <= CW'(DEPTH);
      almost_full  <= (AF_THRESH == 0);
      almost_empty <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fill_level   <= fill_next;
      free_space   <= CW'(DEPTH) - fill_next;
      almost_full  <= (int'(fill_next) >= AF_THRESH);
      almost_empty <= (int'(fill_next) <= AE_THRESH);
    end
  end

  glip_jtag_pfifo_ram #(
    .WIDTH (WW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_word),
    .rd_addr (rd_ptr),
    .rd_data (rd_word)
  );

`ifdef GLIP_JTAG_PFIFO_PACKET_EN
  logic [CW-1:0] pkt_count;
  logic          pkt_in, pkt_out;

  assign wr_word  = {in_last, in_data};
  assign out_data = rd_word[DATA_WIDTH-1:0];
  assign out_last = rd_word[DATA_WIDTH];
  assign pkt_in   = push && in_last;
  assign pkt_out  = pop && out_last;

  // A full FIFO is released even without a complete packet, otherwise a packet
  // longer than DEPTH could never drain.
  assign out_valid = (fill_level != '0) &&
                     ((pkt_count != '0) || (fill_level == CW'(DEPTH)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_count <= '0;
    end else if (pkt_in && !pkt_out) begin
      pkt_count <= pkt_count + CW'(1);
    end else if (pkt_out && !pkt_in) begin
      pkt_count <= pkt_count - CW'(1);
    end
  end
`else
  logic unused_last;

  assign unused_last = in_last;
  assign wr_word     = in_data;
  assign out_data    = rd_word;
  assign out_last    = 1'b0;
  assign out_valid   = (fill_level != '0);
`endif

endmodule
